// File: rtl/snes_mem_arbiter_if.sv
// Bundles the console-side strobes and the memory-controller port of the arbiter.
// slave modport: the arbiter itself. master modport: console core plus SDRAM
// controller (or a bench standing in for both).
interface snes_mem_arbiter_if;
   logic        ROM_RD;
   logic [21:0] ROM_ADDR;
   logic [7:0]  ROM_Q;
   logic        ROM_RDY;

   logic        WRAM_RD;
   logic        WRAM_WR;
   logic [16:0] WRAM_ADDR;
   logic [7:0]  WRAM_D;
   logic [7:0]  WRAM_Q;
   logic        WRAM_RDY;

   logic        ARAM_RD;
   logic        ARAM_WR;
   logic [15:0] ARAM_ADDR;
   logic [7:0]  ARAM_D;
   logic [7:0]  ARAM_Q;
   logic        ARAM_RDY;

   logic        MEM_REQ;
   logic        MEM_WE;
   logic [22:0] MEM_ADDR;
   logic [7:0]  MEM_D;
   logic [7:0]  MEM_Q;
   logic        MEM_ACK;
   logic        BUSY;

   modport slave (
      input  ROM_RD, ROM_ADDR,
      input  WRAM_RD, WRAM_WR, WRAM_ADDR, WRAM_D,
      input  ARAM_RD, ARAM_WR, ARAM_ADDR, ARAM_D,
      input  MEM_Q, MEM_ACK,
      output ROM_Q, ROM_RDY, WRAM_Q, WRAM_RDY, ARAM_Q, ARAM_RDY,
      output MEM_REQ, MEM_WE, MEM_ADDR, MEM_D, BUSY
   );

   modport master (
      output ROM_RD, ROM_ADDR,
      output WRAM_RD, WRAM_WR, WRAM_ADDR, WRAM_D,
      output ARAM_RD, ARAM_WR, ARAM_ADDR, ARAM_D,
      output MEM_Q, MEM_ACK,
      input  ROM_Q, ROM_RDY, WRAM_Q, WRAM_RDY, ARAM_Q, ARAM_RDY,
      input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_D, BUSY
   );
endinterface

// File: rtl/snes_mem_arbiter.sv
// Purpose: shares one byte-wide SDRAM port among ROM, WRAM and ARAM requesters.
// Latency: strobe -> MEM_REQ after 1 edge; MEM_ACK -> *_RDY after 1 edge (min 3 edges total).
// Backpressure: one pending slot per requester, newer strobe overwrites; MEM_REQ held until MEM_ACK.
// Ports: MCLK/RST (async active-high), bus.slave carrying the requester strobes,
// read data/ready pulses, and the MEM_* request/ack handshake plus BUSY.
module snes_mem_arbiter #(
   parameter logic [22:0] WRAM_BASE = 23'h600000,
   parameter logic [22:0] ARAM_BASE = 23'h620000,
   parameter int unsigned STARVE    = 3
) (
   input  logic               MCLK,
   input  logic               RST,
   snes_mem_arbiter_if.slave  bus
);
   typedef enum logic {S_IDLE, S_WAIT} state_t;
   typedef enum logic [1:0] {OWN_ROM, OWN_WRAM, OWN_ARAM} owner_t;

   localparam logic [3:0] STARVE_C = 4'(STARVE);

   state_t      r_state, w_state_nxt;
   owner_t      r_owner, w_grant_own;
   logic        w_grant, w_done;

   // pending slots
   logic        r_rom_vld;
   logic [21:0] r_rom_addr;
   logic        r_wram_vld, r_wram_we;
   logic [16:0] r_wram_addr;
   logic [7:0]  r_wram_dat;
   logic        r_aram_vld, r_aram_we;
   logic [15:0] r_aram_addr;
   logic [7:0]  r_aram_dat;
   logic [3:0]  r_rom_age;

   logic        r_mem_req, r_mem_we, r_busy;
   logic [22:0] r_mem_addr;
   logic [7:0]  r_mem_d;
   logic [7:0]  r_rom_q, r_wram_q, r_aram_q;
   logic        r_rom_rdy, r_wram_rdy, r_aram_rdy;

   logic [22:0] w_wram_full, w_aram_full;
   logic        w_sel_we;
   logic [22:0] w_sel_addr;
   logic [7:0]  w_sel_dat;

   // 23-bit sums wrap naturally
   assign w_wram_full = WRAM_BASE + {6'd0, r_wram_addr};
   assign w_aram_full = ARAM_BASE + {7'd0, r_aram_addr};

   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_done      = 1'b0;
      w_grant_own = OWN_ROM;
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_dat   = '0;
      case (r_state)
         S_IDLE: begin
            if (r_rom_vld || r_wram_vld || r_aram_vld) begin
               w_grant     = 1'b1;
               w_state_nxt = S_WAIT;
               // a starved ROM request jumps ahead of the fixed order
               if (r_rom_vld && (r_rom_age == STARVE_C)) w_grant_own = OWN_ROM;
               else if (r_aram_vld)                      w_grant_own = OWN_ARAM;
               else if (r_wram_vld)                      w_grant_own = OWN_WRAM;
               else                                      w_grant_own = OWN_ROM;
            end
         end
         S_WAIT: begin
            if (bus.MEM_ACK) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      case (w_grant_own)
         OWN_WRAM: begin w_sel_we = r_wram_we; w_sel_addr = w_wram_full; w_sel_dat = r_wram_dat; end
         OWN_ARAM: begin w_sel_we = r_aram_we; w_sel_addr = w_aram_full; w_sel_dat = r_aram_dat; end
         default:  begin w_sel_we = 1'b0; w_sel_addr = {1'b0, r_rom_addr}; w_sel_dat = 8'h00; end
      endcase
   end

   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         r_rom_vld   <= 1'b0;
         r_rom_addr  <= '0;
         r_wram_vld  <= 1'b0;
         r_wram_we   <= 1'b0;
         r_wram_addr <= '0;
         r_wram_dat  <= '0;
         r_aram_vld  <= 1'b0;
         r_aram_we   <= 1'b0;
         r_aram_addr <= '0;
         r_aram_dat  <= '0;
         r_rom_age   <= '0;
         r_owner     <= OWN_ROM;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_busy      <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_d     <= '0;
         r_rom_q     <= '0;
         r_wram_q    <= '0;
         r_aram_q    <= '0;
         r_rom_rdy   <= 1'b0;
         r_wram_rdy  <= 1'b0;
         r_aram_rdy  <= 1'b0;
      end else begin
         // a strobe on the grant edge reloads the slot, so load beats clear
         if (bus.ROM_RD) begin
            r_rom_vld  <= 1'b1;
            r_rom_addr <= bus.ROM_ADDR;
         end else if (w_grant && (w_grant_own == OWN_ROM)) begin
            r_rom_vld  <= 1'b0;
         end

         if (bus.WRAM_RD || bus.WRAM_WR) begin
            r_wram_vld  <= 1'b1;
            r_wram_we   <= bus.WRAM_WR;
            r_wram_addr <= bus.WRAM_ADDR;
            r_wram_dat  <= bus.WRAM_D;
         end else if (w_grant && (w_grant_own == OWN_WRAM)) begin
            r_wram_vld  <= 1'b0;
         end

         if (bus.ARAM_RD || bus.ARAM_WR) begin
            r_aram_vld  <= 1'b1;
            r_aram_we   <= bus.ARAM_WR;
            r_aram_addr <= bus.ARAM_ADDR;
            r_aram_dat  <= bus.ARAM_D;
         end else if (w_grant && (w_grant_own == OWN_ARAM)) begin
            r_aram_vld  <= 1'b0;
         end

         // age counts non-ROM grants that overtook a waiting ROM request
         if (!r_rom_vld) begin
            r_rom_age <= '0;
         end else if (w_grant) begin
            if (w_grant_own == OWN_ROM)    r_rom_age <= '0;
            else if (r_rom_age < STARVE_C) r_rom_age <= r_rom_age + 4'd1;
         end

         r_rom_rdy  <= 1'b0;
         r_wram_rdy <= 1'b0;
         r_aram_rdy <= 1'b0;

         if (w_grant) begin
            r_owner    <= w_grant_own;
            r_mem_req  <= 1'b1;
            r_busy     <= 1'b1;
            r_mem_we   <= w_sel_we;
            r_mem_addr <= w_sel_addr;
            r_mem_d    <= w_sel_dat;
         end

         if (w_done) begin
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
            case (r_owner)
               OWN_WRAM: begin r_wram_rdy <= 1'b1; if (!r_mem_we) r_wram_q <= bus.MEM_Q; end
               OWN_ARAM: begin r_aram_rdy <= 1'b1; if (!r_mem_we) r_aram_q <= bus.MEM_Q; end
               default:  begin r_rom_rdy  <= 1'b1; if (!r_mem_we) r_rom_q  <= bus.MEM_Q; end
            endcase
         end
      end
   end

   assign bus.MEM_REQ  = r_mem_req;
   assign bus.MEM_WE   = r_mem_we;
   assign bus.MEM_ADDR = r_mem_addr;
   assign bus.MEM_D    = r_mem_d;
   assign bus.BUSY     = r_busy;
   assign bus.ROM_Q    = r_rom_q;
   assign bus.ROM_RDY  = r_rom_rdy;
   assign bus.WRAM_Q   = r_wram_q;
   assign bus.WRAM_RDY = r_wram_rdy;
   assign bus.ARAM_Q   = r_aram_q;
   assign bus.ARAM_RDY = r_aram_rdy;
endmodule

// File: tb/tb_snes_mem_arbiter.sv
// Bench for snes_mem_arbiter: acts as console core and SDRAM controller,
// predicts every cycle from a requester-indexed transaction model.
// Requester index: 0 = ROM, 1 = WRAM, 2 = ARAM.
module tb_snes_mem_arbiter;
   localparam logic [22:0] WB = 23'h600000;
   localparam logic [22:0] AB = 23'h7F8000;
   localparam int          ST = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   snes_mem_arbiter_if bus();

   snes_mem_arbiter #(.WRAM_BASE(WB), .ARAM_BASE(AB), .STARVE(ST)) dut (
      .MCLK(clk),
      .RST (rst),
      .bus (bus)
   );

   int n_pass = 0;
   int n_total = 0;

   // reference model
   bit          m_v[3];
   bit          m_we[3];
   logic [22:0] m_a[3];
   logic [7:0]  m_d[3];
   int          m_age;
   int          m_own;
   bit          m_ever;
   logic [22:0] m_addr;
   bit          m_mwe;
   logic [7:0]  m_md;
   logic [7:0]  m_q[3];
   bit          m_rdy[3];

   // strobes queued for the coming edge
   bit          s_on[3];
   bit          s_we[3];
   logic [22:0] s_a[3];
   logic [7:0]  s_d[3];

   // controller behaviour
   int          ack_delay = 2;
   int          wait_cnt = 0;
   bit          rand_delay = 0;
   bit          spur = 0;
   bit          q_rand = 1;
   logic [7:0]  q_fix = 8'h00;

   // observation logs
   logic [22:0] log_addr[$];
   bit          log_we[$];
   logic [7:0]  log_d[$];
   int          rdy_cnt[3];
   bit          prev_req = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int r = 0; r < 3; r++) begin
         m_v[r] = 0; m_we[r] = 0; m_a[r] = '0; m_d[r] = '0; m_q[r] = '0; m_rdy[r] = 0;
      end
      m_age = 0; m_own = -1; m_ever = 0; m_addr = '0; m_mwe = 0; m_md = '0;
   endtask

   task automatic clear_logs();
      log_addr.delete(); log_we.delete(); log_d.delete();
      for (int r = 0; r < 3; r++) rdy_cnt[r] = 0;
   endtask

   task automatic strobe(input int r, input bit we, input bit both,
                         input logic [22:0] raw, input logic [7:0] d);
      s_on[r] = 1;
      s_d[r]  = d;
      case (r)
         0: begin
            bus.ROM_RD = 1'b1; bus.ROM_ADDR = raw[21:0];
            s_we[r] = 0; s_d[r] = 8'h00; s_a[r] = {1'b0, raw[21:0]};
         end
         1: begin
            bus.WRAM_RD = !we || both; bus.WRAM_WR = we || both;
            bus.WRAM_ADDR = raw[16:0]; bus.WRAM_D = d;
            s_we[r] = we || both; s_a[r] = WB + {6'd0, raw[16:0]};
         end
         default: begin
            bus.ARAM_RD = !we || both; bus.ARAM_WR = we || both;
            bus.ARAM_ADDR = raw[15:0]; bus.ARAM_D = d;
            s_we[r] = we || both; s_a[r] = AB + {7'd0, raw[15:0]};
         end
      endcase
   endtask

   task automatic tick();
      bit         ack;
      logic [7:0] q;
      int         g;
      bit         rom_was;
      ack = 0;
      q = q_rand ? 8'($urandom) : q_fix;
      if (m_own >= 0) begin
         wait_cnt++;
         if (wait_cnt >= ack_delay) ack = 1;
      end else if (spur && ($urandom_range(3) == 0)) begin
         ack = 1;
      end
      bus.MEM_ACK = ack;
      bus.MEM_Q   = q;
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else begin
         g = -1;
         rom_was = m_v[0];
         for (int r = 0; r < 3; r++) m_rdy[r] = 0;
         if (m_own >= 0) begin
            if (ack) begin
               if (!m_mwe) m_q[m_own] = q;
               m_rdy[m_own] = 1;
               m_own = -1;
            end
         end else if (m_v[0] || m_v[1] || m_v[2]) begin
            if (m_v[0] && m_age == ST) g = 0;
            else if (m_v[2])           g = 2;
            else if (m_v[1])           g = 1;
            else                       g = 0;
            m_own = g; m_ever = 1;
            m_addr = m_a[g]; m_mwe = m_we[g]; m_md = m_d[g];
            wait_cnt = 0;
            if (rand_delay) ack_delay = $urandom_range(1, 5);
         end
         if (!rom_was || g == 0) m_age = 0;
         else if (g > 0 && m_age < ST) m_age++;
         for (int r = 0; r < 3; r++) begin
            if (g == r) m_v[r] = 0;
            if (s_on[r]) begin
               m_v[r] = 1; m_we[r] = s_we[r]; m_a[r] = s_a[r]; m_d[r] = s_d[r];
            end
         end
      end
      for (int r = 0; r < 3; r++) s_on[r] = 0;
      bus.ROM_RD = 0; bus.WRAM_RD = 0; bus.WRAM_WR = 0; bus.ARAM_RD = 0; bus.ARAM_WR = 0;

      chk("MEM_REQ", bus.MEM_REQ, m_own >= 0);
      chk("BUSY", bus.BUSY, m_own >= 0);
      if (m_own >= 0 || !m_ever) begin
         chk("MEM_ADDR", bus.MEM_ADDR, m_addr);
         chk("MEM_WE", bus.MEM_WE, m_mwe);
         if (m_mwe || !m_ever) chk("MEM_D", bus.MEM_D, m_md);
      end
      chk("ROM_RDY", bus.ROM_RDY, m_rdy[0]);
      chk("WRAM_RDY", bus.WRAM_RDY, m_rdy[1]);
      chk("ARAM_RDY", bus.ARAM_RDY, m_rdy[2]);
      chk("ROM_Q", bus.ROM_Q, m_q[0]);
      chk("WRAM_Q", bus.WRAM_Q, m_q[1]);
      chk("ARAM_Q", bus.ARAM_Q, m_q[2]);

      if (bus.MEM_REQ && !prev_req) begin
         log_addr.push_back(bus.MEM_ADDR); log_we.push_back(bus.MEM_WE); log_d.push_back(bus.MEM_D);
      end
      prev_req = bus.MEM_REQ;
      rdy_cnt[0] += int'(bus.ROM_RDY);
      rdy_cnt[1] += int'(bus.WRAM_RDY);
      rdy_cnt[2] += int'(bus.ARAM_RDY);
   endtask

   task automatic drain();
      int n = 0;
      while ((m_own >= 0 || m_v[0] || m_v[1] || m_v[2]) && n < 300) begin
         tick();
         n++;
      end
      chk("drain_timeout", n < 300, 1'b1);
      tick();
   endtask

   initial begin
      int n;
      bus.ROM_RD = 0; bus.ROM_ADDR = '0;
      bus.WRAM_RD = 0; bus.WRAM_WR = 0; bus.WRAM_ADDR = '0; bus.WRAM_D = '0;
      bus.ARAM_RD = 0; bus.ARAM_WR = 0; bus.ARAM_ADDR = '0; bus.ARAM_D = '0;
      bus.MEM_Q = '0; bus.MEM_ACK = 0;
      for (int r = 0; r < 3; r++) begin s_on[r] = 0; s_we[r] = 0; s_a[r] = '0; s_d[r] = '0; end
      model_reset();
      clear_logs();

      // reset state
      tick();
      tick();
      chk("rst_mem_req", bus.MEM_REQ, 1'b0);
      chk("rst_mem_addr", bus.MEM_ADDR, 23'h0);
      chk("rst_rom_q", bus.ROM_Q, 8'h00);
      rst = 0;
      tick();

      // single ROM read, ACK 4 cycles after MEM_REQ
      clear_logs();
      q_rand = 0; q_fix = 8'h5A; ack_delay = 4;
      strobe(0, 0, 0, 23'h00ABCD, 8'h00);
      tick();
      tick();
      chk("rom_req_addr", bus.MEM_ADDR, 23'h00ABCD);
      chk("rom_req_we", bus.MEM_WE, 1'b0);
      drain();
      chk("rom_q", bus.ROM_Q, 8'h5A);
      chk("rom_rdy_count", rdy_cnt[0], 1);
      chk("rom_busy_after", bus.BUSY, 1'b0);

      // simultaneous strobes
      clear_logs();
      q_rand = 1; ack_delay = 2;
      strobe(0, 0, 0, 23'h000100, 8'h00);
      strobe(1, 1, 0, 23'h01FFFF, 8'h33);
      strobe(2, 0, 0, 23'h000040, 8'h00);
      tick();
      drain();
      chk("sim_count", log_addr.size(), 3);
      chk("sim_first", log_addr[0], 23'h7F8040);
      chk("sim_second", log_addr[1], 23'h61FFFF);
      chk("sim_second_we", log_we[1], 1'b1);
      chk("sim_second_d", log_d[1], 8'h33);
      chk("sim_third", log_addr[2], 23'h000100);
      chk("sim_rdy_total", rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2], 3);

      // ROM starvation under continuous ARAM/WRAM traffic
      clear_logs();
      strobe(0, 0, 0, 23'h0000F0, 8'h00);
      n = 0;
      while (log_addr.size() < 4 && n < 100) begin
         strobe(1, 0, 0, 23'h000005, 8'h00);
         strobe(2, 0, 0, 23'h000007, 8'h00);
         tick();
         n++;
      end
      chk("starve_timeout", n < 100, 1'b1);
      drain();
      chk("starve_aram0", log_addr[0], 23'h7F8007);
      chk("starve_rom_4th", log_addr[3], 23'h0000F0);

      // overwrite while another transaction is outstanding
      clear_logs();
      ack_delay = 5;
      strobe(2, 0, 0, 23'h000001, 8'h00);
      tick();
      tick();
      strobe(1, 0, 0, 23'h000020, 8'h00);
      tick();
      strobe(1, 0, 0, 23'h000010, 8'h00);
      tick();
      drain();
      chk("ovw_count", log_addr.size(), 2);
      chk("ovw_addr", log_addr[1], 23'h600010);

      // reload on the grant edge
      clear_logs();
      ack_delay = 2;
      strobe(1, 0, 0, 23'h000030, 8'h00);
      tick();
      strobe(1, 0, 0, 23'h000040, 8'h00);
      tick();
      drain();
      chk("reload_count", log_addr.size(), 2);
      chk("reload_first", log_addr[0], 23'h600030);
      chk("reload_second", log_addr[1], 23'h600040);
      chk("reload_rdy", rdy_cnt[1], 2);

      // ARAM window wraps past the top of memory
      clear_logs();
      strobe(2, 0, 0, 23'h00A000, 8'h00);
      tick();
      drain();
      chk("wrap_addr", log_addr[0], 23'h002000);

      // randomized traffic with random latency and stray ACKs while idle
      rand_delay = 1; spur = 1;
      for (int i = 0; i < 600; i++) begin
         for (int r = 0; r < 3; r++) begin
            if ($urandom_range(3) == 0)
               strobe(r, 1'($urandom), ($urandom_range(7) == 0), 23'($urandom), 8'($urandom));
         end
         tick();
      end
      drain();
      rand_delay = 0; spur = 0;

      // reset while a transaction is outstanding with ROM and ARAM pending
      ack_delay = 20;
      strobe(1, 0, 0, 23'h000002, 8'h00);
      tick();
      tick();
      strobe(0, 0, 0, 23'h000200, 8'h00);
      strobe(2, 0, 0, 23'h000300, 8'h00);
      tick();
      chk("pre_rst_req", bus.MEM_REQ, 1'b1);
      clear_logs();
      #2;
      rst = 1;
      #1;
      chk("rst_drops_req", bus.MEM_REQ, 1'b0);
      chk("rst_drops_busy", bus.BUSY, 1'b0);
      model_reset();
      strobe(2, 0, 0, 23'h000400, 8'h00);
      tick();
      tick();
      rst = 0;
      ack_delay = 2;
      for (int i = 0; i < 4; i++) tick();
      chk("rst_no_txn", log_addr.size(), 0);
      chk("rst_no_rdy", rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2], 0);
      strobe(1, 1, 0, 23'h000055, 8'hC3);
      tick();
      drain();
      chk("rst_fresh_count", log_addr.size(), 1);
      chk("rst_fresh_addr", log_addr[0], 23'h600055);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/snes_mem_arbiter.md
# snes_mem_arbiter

Shares one external byte-wide memory port (SDRAM controller front end) among three SNES requesters: cartridge ROM reads, WRAM reads/writes, and ARAM reads/writes. It sits between the console core's memory strobes and the SDRAM controller. It latches one pending request per requester, grants by fixed priority with a ROM anti-starvation override, and returns read data with a one-cycle ready pulse.

## Interface
Parameters:
- `WRAM_BASE`, default 23'h600000: byte offset of the 128 KB WRAM window in memory.
- `ARAM_BASE`, default 23'h620000: byte offset of the 64 KB ARAM window.
- `STARVE`, default 3: number of consecutive non-ROM grants after which a pending ROM request wins. Range 1..15.

Ports:
- `MCLK`  in  1  master clock; all logic is on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `ROM_RD`  in  1  one-cycle read strobe.
- `ROM_ADDR`  in  22  ROM byte address; memory address = {1'b0, ROM_ADDR}.
- `ROM_Q`  out  8  ROM read data.
- `ROM_RDY`  out  1  one-cycle pulse when ROM_Q is valid.
- `WRAM_RD`, `WRAM_WR`  in  1  one-cycle strobes.
- `WRAM_ADDR`  in  17  WRAM address.
- `WRAM_D`  in  8  write data.
- `WRAM_Q`  out  8  read data.
- `WRAM_RDY`  out  1  completion pulse, for reads and writes.
- `ARAM_RD`, `ARAM_WR`, `ARAM_ADDR` (16), `ARAM_D` (8), `ARAM_Q` (8), `ARAM_RDY`: same meaning as the WRAM ports.
- `MEM_REQ`  out  1  request to the memory controller; held high until acknowledged.
- `MEM_WE`  out  1  1 = write.
- `MEM_ADDR`  out  23  byte address.
- `MEM_D`  out  8  write data.
- `MEM_Q`  in  8  read data, valid in the cycle MEM_ACK is high.
- `MEM_ACK`  in  1  one-cycle completion from the controller.
- `BUSY`  out  1  high while a memory transaction is outstanding.

## Operation
- Pending slots, one per requester, each holding {valid, we, addr, data}.
  - A strobe sampled at an edge loads the slot: address, write data, and we (WR=1, RD=0).
  - If RD and WR are both high, WR wins.
  - A strobe to a slot that is still pending replaces its contents (last wins).
  - A slot clears at the edge its request is granted. A strobe in that same edge reloads the slot and is served later.
- FSM has two states, IDLE and WAIT.
  - IDLE with any slot valid: select a requester, register MEM_ADDR/MEM_WE/MEM_D, set MEM_REQ=1 and BUSY=1, go to WAIT.
  - IDLE with no slot valid: remain in IDLE.
  - WAIT: hold all MEM_* outputs stable. On MEM_ACK: MEM_REQ=0, BUSY=0; for a read, load MEM_Q into the owner's *_Q; pulse the owner's *_RDY; go to IDLE.
  - MEM_ACK in IDLE is ignored.
- Priority: ARAM > WRAM > ROM, except when `rom_age` == STARVE and the ROM slot is valid; then ROM is granted first.
- `rom_age` (4 bits) rules:
  - Increments on each non-ROM grant made while the ROM slot is valid.
  - Saturates at STARVE.
  - Clears on a ROM grant, or whenever the ROM slot is empty.
- Address formation: WRAM uses WRAM_BASE + WRAM_ADDR and ARAM uses ARAM_BASE + ARAM_ADDR. Both sums are 23-bit and wrap modulo 2^23.
- *_Q holds its last read value across writes and other requesters' traffic.

## Timing
- Reset values:
  - MEM_REQ, MEM_WE, BUSY and all *_RDY are 0.
  - MEM_ADDR, MEM_D and all *_Q are 0.
  - All slots are invalid, `rom_age` = 0, state = IDLE.
- Reset asserted mid-transaction drops MEM_REQ immediately and discards every pending request; no RDY is issued for them.
- Strobe sampled at edge k → MEM_REQ high after edge k+1 (if idle and the request wins).
- MEM_ACK sampled at edge m → *_RDY high and *_Q valid after edge m; RDY drops after edge m+1.
- Minimum request-to-RDY latency is 3 edges.
- Next grant is made at edge m+1 at the earliest, so MEM_REQ is low for at least one cycle between transactions.
- Throughput: one transaction per (controller latency + 1) cycles.

## Test plan
- ROM read, single: ROM_RD at ROM_ADDR=22'h00ABCD, controller ACKs 4 cycles after MEM_REQ with MEM_Q=8'h5A → MEM_ADDR=23'h00ABCD, MEM_WE=0, ROM_Q=8'h5A, one ROM_RDY pulse, BUSY low afterwards.
- Simultaneous strobes: ROM_RD, WRAM_WR (WRAM_ADDR=17'h1FFFF, data 8'h33) and ARAM_RD in the same cycle → grant order ARAM, WRAM (MEM_ADDR=23'h61FFFF, MEM_D=8'h33, MEM_WE=1), ROM; exactly three RDY pulses.
- Starvation, STARVE=3: ROM pending while ARAM and WRAM strobe every cycle → ROM is granted as the 4th transaction; `rom_age` returns to 0.
- Overwrite and reload:
  - Second WRAM_RD to 17'h00010 before the first is granted → only 23'h600010 is issued.
  - WRAM_RD coinciding with the grant of the current WRAM request → two WRAM transactions.
- Reset mid-WAIT: assert RST while MEM_REQ=1 with ROM and ARAM pending → MEM_REQ=0 immediately, no RDY pulses, first transaction after reset release comes from a fresh strobe only.
- ARAM wrap: ARAM_BASE=23'h7F8000, ARAM_ADDR=16'hA000 → MEM_ADDR=23'h002000.
